// File: rtl/coffee_sequencer.sv
// Coffee machine stage sequencer.
// Runs the recipe stages in the order HEAT -> GRIND -> BREW (-> MILK for
// latte). Each stage arms an external seconds timer. A GAP state follows
// every stage and waits until the timer has cleared before the next stage
// starts.
// Optional feature: define COFFEE_SEQ_WATCHDOG_EN to add a per-stage cycle
// watchdog. If a stage runs for WDOG_CYCLES cycles it pulses err and enters
// FAULT.
// Ports:
//   clk_100MHz, rst_n            : clock, async active-low reset
//   start_btn, cancel, drink_sel : brew request, abort, recipe select
//   t_expired                    : stage-done flag from the seconds timer
//   start_timer, timer_value     : timer enable and stage duration (s)
//   heater_on, grinder_on,
//   pump_on, milk_on             : actuator enables
//   busy, done, err, state       : status; done/err are one-cycle pulses
module coffee_sequencer #(
  parameter logic [31:0] WDOG_CYCLES = 32'd500_000_000
) (
  input  logic       clk_100MHz,
  input  logic       rst_n,
  input  logic       start_btn,
  input  logic       cancel,
  input  logic [1:0] drink_sel,
  input  logic       t_expired,
  output logic       start_timer,
  output logic [1:0] timer_value,
  output logic       heater_on,
  output logic       grinder_on,
  output logic       pump_on,
  output logic       milk_on,
  output logic       busy,
  output logic       done,
  output logic       err,
  output logic [2:0] state
);

  localparam int unsigned STATE_W = 3;
  localparam int unsigned SEL_W   = 2;

  localparam logic [SEL_W-1:0] SEL_AMERICANO = SEL_W'(1);
  localparam logic [SEL_W-1:0] SEL_LATTE     = SEL_W'(2);
  localparam logic [SEL_W-1:0] SEL_INVALID   = SEL_W'(3);

  typedef enum logic [STATE_W-1:0] {
    S_IDLE  = 3'd0,
    S_HEAT  = 3'd1,
    S_GRIND = 3'd2,
    S_BREW  = 3'd3,
    S_MILK  = 3'd4,
    S_GAP   = 3'd5,
    S_FAULT = 3'd6
  } state_t;

  state_t           state_q, state_d;
  state_t           prev_q, prev_d;       // last stage run, selects GAP's successor
  logic [SEL_W-1:0] recipe_q, recipe_d;
  logic             gap_first_q, gap_first_d;

  logic             start_timer_q, start_timer_d;
  logic [1:0]       timer_value_q, timer_value_d;
  logic             heater_q, heater_d;
  logic             grinder_q, grinder_d;
  logic             pump_q, pump_d;
  logic             milk_q, milk_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             err_q, err_d;

  function automatic logic is_stage(input state_t s);
    return (s == S_HEAT) || (s == S_GRIND) || (s == S_BREW) || (s == S_MILK);
  endfunction

  // Stage duration in seconds for the latched recipe.
  function automatic logic [1:0] stage_dur(input state_t s, input logic [SEL_W-1:0] r);
    logic [1:0] d;
    d = 2'd0;
    case (s)
      S_HEAT:  d = (r == SEL_AMERICANO) ? 2'd3 : 2'd2;
      S_GRIND: d = 2'd1;
      S_BREW:  d = (r == SEL_AMERICANO) ? 2'd3 : 2'd2;
      S_MILK:  d = 2'd3;
      default: d = 2'd0;
    endcase
    return d;
  endfunction

`ifdef COFFEE_SEQ_WATCHDOG_EN
  logic [31:0] wdog_q, wdog_d;
  logic        wdog_hit_c;

  assign wdog_hit_c = (wdog_q >= (WDOG_CYCLES - 32'd1));
`else
  logic unused_wdog_cfg;
  assign unused_wdog_cfg = ^WDOG_CYCLES;
`endif

  // Next-state, next-output logic.
  always_comb begin
    state_d     = state_q;
    prev_d      = prev_q;
    recipe_d    = recipe_q;
    gap_first_d = gap_first_q;
    done_d      = 1'b0;
    err_d       = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start_btn && !cancel) begin
          if (drink_sel == SEL_INVALID) begin
            err_d = 1'b1;
          end else begin
            recipe_d = drink_sel;
            state_d  = S_HEAT;
          end
        end
      end
      S_HEAT, S_GRIND, S_BREW, S_MILK: begin
        if (t_expired) begin
          state_d     = S_GAP;
          prev_d      = state_q;
          gap_first_d = 1'b1;
        end
`ifdef COFFEE_SEQ_WATCHDOG_EN
        else if (wdog_hit_c) begin
          state_d = S_FAULT;
          err_d   = 1'b1;
        end
`endif
      end
      S_GAP: begin
        // Hold at least two cycles with the timer disabled so it clears.
        gap_first_d = 1'b0;
        if (!gap_first_q && !t_expired) begin
          case (prev_q)
            S_HEAT:  state_d = S_GRIND;
            S_GRIND: state_d = S_BREW;
            S_BREW: begin
              if (recipe_q == SEL_LATTE) begin
                state_d = S_MILK;
              end else begin
                state_d = S_IDLE;
                done_d  = 1'b1;
              end
            end
            default: begin
              state_d = S_IDLE;
              done_d  = 1'b1;
            end
          endcase
        end
      end
      S_FAULT: state_d = S_FAULT;
      default: state_d = S_IDLE;
    endcase

    // Cancel overrides everything outside IDLE.
    if ((state_q != S_IDLE) && cancel) begin
      state_d = S_IDLE;
      done_d  = 1'b0;
      err_d   = 1'b0;
    end

    // Outputs are decoded from the next state so they register alongside it.
    start_timer_d = is_stage(state_d);
    timer_value_d = stage_dur(state_d, recipe_d);
    heater_d      = (state_d == S_HEAT);
    grinder_d     = (state_d == S_GRIND);
    pump_d        = (state_d == S_BREW);
    milk_d        = (state_d == S_MILK);
    busy_d        = (state_d != S_IDLE);
  end

`ifdef COFFEE_SEQ_WATCHDOG_EN
  // Watchdog: cleared on stage entry, counts every cycle spent in a stage.
  always_comb begin
    wdog_d = wdog_q;
    if (is_stage(state_q)) begin
      wdog_d = wdog_q + 32'd1;
    end
    if (is_stage(state_d) && (state_d != state_q)) begin
      wdog_d = 32'd0;
    end
  end

  always_ff @(posedge clk_100MHz or negedge rst_n) begin
    if (!rst_n) begin
      wdog_q <= 32'd0;
    end else begin
      wdog_q <= wdog_d;
    end
  end
`endif

  // State and output registers.
  always_ff @(posedge clk_100MHz or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      prev_q        <= S_IDLE;
      recipe_q      <= SEL_W'(0);
      gap_first_q   <= 1'b0;
      start_timer_q <= 1'b0;
      timer_value_q <= 2'd0;
      heater_q      <= 1'b0;
      grinder_q     <= 1'b0;
      pump_q        <= 1'b0;
      milk_q        <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      err_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      prev_q        <= prev_d;
      recipe_q      <= recipe_d;
      gap_first_q   <= gap_first_d;
      start_timer_q <= start_timer_d;
      timer_value_q <= timer_value_d;
      heater_q      <= heater_d;
      grinder_q     <= grinder_d;
      pump_q        <= pump_d;
      milk_q        <= milk_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      err_q         <= err_d;
    end
  end

  assign start_timer = start_timer_q;
  assign timer_value = timer_value_q;
  assign heater_on   = heater_q;
  assign grinder_on  = grinder_q;
  assign pump_on     = pump_q;
  assign milk_on     = milk_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign err         = err_q;
  assign state       = STATE_W'(state_q);

endmodule

// File: tb/tb_coffee_sequencer.sv
// Self-checking bench for coffee_sequencer (default build).
// A recipe-level reference model predicts every output on every cycle.
// Directed scenarios also pin literal expectations.
module tb_coffee_sequencer;

  localparam int SCALE = 2;  // clock cycles per simulated timer second

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start_btn, cancel, t_expired;
  logic [1:0] drink_sel;
  logic       start_timer, heater_on, grinder_on, pump_on, milk_on;
  logic       busy, done, err;
  logic [1:0] timer_value;
  logic [2:0] state;

  int n_pass = 0;
  int n_total = 0;

  coffee_sequencer dut (
    .clk_100MHz (clk),
    .rst_n      (rst_n),
    .start_btn  (start_btn),
    .cancel     (cancel),
    .drink_sel  (drink_sel),
    .t_expired  (t_expired),
    .start_timer(start_timer),
    .timer_value(timer_value),
    .heater_on  (heater_on),
    .grinder_on (grinder_on),
    .pump_on    (pump_on),
    .milk_on    (milk_on),
    .busy       (busy),
    .done       (done),
    .err        (err),
    .state      (state)
  );

  always #5 clk = ~clk;

  // Reference model: a brew is a list of stage durations plus a position.
  int m_mode;      // 0 idle, 1 running a stage, 2 in the gap after a stage
  int m_idx;
  int m_n;
  int m_gap_age;
  int m_dur[4];
  bit e_done, e_err;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_mode = 0; m_idx = 0; m_n = 0; m_gap_age = 0;
      e_done = 1'b0; e_err = 1'b0;
    end else begin
      e_done = 1'b0;
      e_err  = 1'b0;
      if (m_mode == 0) begin
        if (start_btn && !cancel) begin
          if (drink_sel == 2'd3) begin
            e_err = 1'b1;
          end else begin
            m_n      = (drink_sel == 2'd2) ? 4 : 3;
            m_dur[0] = (drink_sel == 2'd1) ? 3 : 2;
            m_dur[1] = 1;
            m_dur[2] = (drink_sel == 2'd1) ? 3 : 2;
            m_dur[3] = 3;
            m_idx    = 0;
            m_mode   = 1;
          end
        end
      end else if (cancel) begin
        m_mode = 0;
      end else if (m_mode == 1) begin
        if (t_expired) begin
          m_mode    = 2;
          m_gap_age = 0;
        end
      end else begin
        // Timer must see start_timer low for two cycles before next stage.
        if (m_gap_age >= 1 && !t_expired) begin
          m_idx = m_idx + 1;
          if (m_idx == m_n) begin
            m_mode = 0;
            e_done = 1'b1;
          end else begin
            m_mode = 1;
          end
        end else begin
          m_gap_age = m_gap_age + 1;
        end
      end
    end
  end

  task automatic chk(input string nm, input int act, input int expv);
    n_total++;
    if (act == expv) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", nm, act, expv, $time);
  endtask

  task automatic check_all();
    int es;
    int stg;
    stg = (m_mode == 1) ? 1 : 0;
    es  = (m_mode == 0) ? 0 : (m_mode == 2) ? 5 : m_idx + 1;
    chk("state", int'(state), es);
    chk("busy", int'(busy), (m_mode != 0) ? 1 : 0);
    chk("start_timer", int'(start_timer), stg);
    chk("timer_value", int'(timer_value), stg ? m_dur[m_idx] : 0);
    chk("heater_on", int'(heater_on), (stg && m_idx == 0) ? 1 : 0);
    chk("grinder_on", int'(grinder_on), (stg && m_idx == 1) ? 1 : 0);
    chk("pump_on", int'(pump_on), (stg && m_idx == 2) ? 1 : 0);
    chk("milk_on", int'(milk_on), (stg && m_idx == 3) ? 1 : 0);
    chk("done", int'(done), int'(e_done));
    chk("err", int'(err), int'(e_err));
  endtask

  // Seconds-timer model: expires after timer_value*SCALE enabled cycles and
  // clears a random 0..3 cycles after the enable drops.
  bit auto_timer = 1'b1;
  int tcnt = 0;
  int hold = 0;

  task automatic timer_update();
    if (start_timer) begin
      tcnt++;
      if (!t_expired && tcnt >= int'(timer_value) * SCALE) begin
        t_expired = 1'b1;
        hold = $urandom_range(0, 3);
      end
    end else begin
      tcnt = 0;
      if (t_expired) begin
        if (hold > 0) hold--;
        else t_expired = 1'b0;
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
    check_all();
    if (auto_timer) timer_update();
  endtask

  task automatic wait_state(input int s, input string nm);
    for (int i = 0; i < 400; i++) begin
      if (int'(state) == s) break;
      step();
    end
    chk(nm, int'(state), s);
  endtask

  task automatic go_idle();
    cancel = 1'b1; start_btn = 1'b0;
    step();
    cancel = 1'b0;
    for (int i = 0; i < 6; i++) step();
  endtask

  int seq[$];
  int tvs[$];
  int exp_seq[7] = '{1, 5, 2, 5, 3, 5, 0};
  int exp_tv[3]  = '{2, 1, 2};
  int last_s;
  int n_done;

  initial begin
    rst_n = 1'b0; start_btn = 1'b0; cancel = 1'b0;
    drink_sel = 2'd0; t_expired = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_state", int'(state), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_timer", int'({start_timer, timer_value}), 0);
    chk("rst_act", int'({heater_on, grinder_on, pump_on, milk_on, done, err}), 0);
    @(negedge clk);
    rst_n = 1'b1;
    step();

    // Espresso, with drink_sel changed mid-brew (must not matter).
    drink_sel = 2'd0; start_btn = 1'b1;
    last_s = 0; n_done = 0;
    for (int i = 0; i < 300; i++) begin
      step();
      if (i == 0) begin start_btn = 1'b0; drink_sel = 2'd2; end
      n_done += int'(done);
      if (int'(state) != last_s) begin
        seq.push_back(int'(state));
        if (state >= 3'd1 && state <= 3'd4) tvs.push_back(int'(timer_value));
        last_s = int'(state);
      end
      if (last_s == 0) break;
    end
    repeat (3) begin step(); n_done += int'(done); end
    chk("esp_seq_len", seq.size(), 7);
    for (int i = 0; i < 7 && i < seq.size(); i++) chk("esp_seq", seq[i], exp_seq[i]);
    chk("esp_tv_len", tvs.size(), 3);
    for (int i = 0; i < 3 && i < tvs.size(); i++) chk("esp_tv", tvs[i], exp_tv[i]);
    chk("esp_done_count", n_done, 1);

    // Invalid recipe.
    drink_sel = 2'd3; start_btn = 1'b1;
    step();
    start_btn = 1'b0;
    chk("inv_err", int'(err), 1);
    chk("inv_state", int'(state), 0);
    chk("inv_busy", int'(busy), 0);
    step();
    chk("inv_err_pulse", int'(err), 0);

    // Cancel in BREW, then start+cancel together in IDLE.
    drink_sel = 2'd1; start_btn = 1'b1;
    step();
    start_btn = 1'b0;
    wait_state(3, "reach_brew");
    cancel = 1'b1;
    step();
    chk("cancel_state", int'(state), 0);
    chk("cancel_pump", int'(pump_on), 0);
    chk("cancel_timer", int'(start_timer), 0);
    chk("cancel_done", int'(done), 0);
    start_btn = 1'b1; drink_sel = 2'd0;
    step();
    chk("start_cancel_state", int'(state), 0);
    chk("start_cancel_busy", int'(busy), 0);
    start_btn = 1'b0;
    go_idle();

    // Latte with t_expired held high after BREW.
    drink_sel = 2'd2; start_btn = 1'b1;
    step();
    start_btn = 1'b0;
    wait_state(3, "latte_brew");
    auto_timer = 1'b0;
    t_expired = 1'b1;
    step();
    for (int i = 0; i < 10; i++) begin
      step();
      chk("gap_hold_state", int'(state), 5);
      chk("gap_hold_timer", int'(start_timer), 0);
    end
    t_expired = 1'b0;
    step();
    chk("milk_state", int'(state), 4);
    chk("milk_tv", int'(timer_value), 3);
    chk("milk_on", int'(milk_on), 1);
    auto_timer = 1'b1; tcnt = 0;
    n_done = 0;
    for (int i = 0; i < 200; i++) begin
      step();
      n_done += int'(done);
      if (state == 3'd0) break;
    end
    chk("latte_done_count", n_done, 1);

    // Asynchronous reset mid-brew.
    drink_sel = 2'd0; start_btn = 1'b1;
    step();
    start_btn = 1'b0;
    wait_state(2, "reach_grind");
    rst_n = 1'b0;
    #1;
    chk("arst_state", int'(state), 0);
    chk("arst_busy", int'(busy), 0);
    chk("arst_outs", int'({start_timer, timer_value, grinder_on}), 0);
    t_expired = 1'b0; tcnt = 0;
    step();
    rst_n = 1'b1;
    step();

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      start_btn = ($urandom_range(0, 9) < 3);
      cancel    = ($urandom_range(0, 99) < 2);
      drink_sel = 2'($urandom_range(0, 3));
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
